// File: rtl/wb_cache_arbiter.sv
// ----------------------------------------------------------------------------
// wb_cache_arbiter
//
// Two-master to one-slave Wishbone classic (single-beat) arbiter that merges
// icache and dcache miss traffic onto the single L2 cache port. It carries
// full cache lines (DATA_W bits with SEL_W byte selects). One master holds the
// grant until L2 acknowledges or the master aborts by dropping cyc.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_cyc/i_stb/i_we/i_sel/i_adr/i_dat_m   icache master request inputs
//   i_dat_s, i_ack                  icache read data / acknowledge
//   d_cyc/d_stb/d_we/d_sel/d_adr/d_dat_m   dcache master request inputs
//   d_dat_s, d_ack                  dcache read data / acknowledge
//   l2_cyc/l2_stb/l2_we/l2_sel/l2_adr/l2_dat_m   request to L2 slave
//   l2_dat_s, l2_ack                read data / single-cycle ack from L2
//
// Handshake: a master requests while cyc && stb. A request seen in IDLE on a
// rising edge is presented to L2 in the following cycle (no combinational
// pass-through from IDLE). While granted, the master's signals are copied to
// L2 and l2_ack is routed back only to that master. The grant ends on the
// edge where l2_ack is 1 (or cyc drops), always returning through IDLE, so
// consecutive L2 transfers are separated by at least one idle cycle.
// ----------------------------------------------------------------------------
module wb_cache_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 128,
    parameter int SEL_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_cyc,
    input  logic              i_stb,
    input  logic              i_we,
    input  logic [SEL_W-1:0]  i_sel,
    input  logic [ADDR_W-1:0] i_adr,
    input  logic [DATA_W-1:0] i_dat_m,
    output logic [DATA_W-1:0] i_dat_s,
    output logic              i_ack,

    input  logic              d_cyc,
    input  logic              d_stb,
    input  logic              d_we,
    input  logic [SEL_W-1:0]  d_sel,
    input  logic [ADDR_W-1:0] d_adr,
    input  logic [DATA_W-1:0] d_dat_m,
    output logic [DATA_W-1:0] d_dat_s,
    output logic              d_ack,

    output logic              l2_cyc,
    output logic              l2_stb,
    output logic              l2_we,
    output logic [SEL_W-1:0]  l2_sel,
    output logic [ADDR_W-1:0] l2_adr,
    output logic [DATA_W-1:0] l2_dat_m,
    input  logic [DATA_W-1:0] l2_dat_s,
    input  logic              l2_ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last_d;          // 1: dcache was the most recently granted master
    logic   req_i, req_d;

    assign req_i = i_cyc & i_stb;
    assign req_d = d_cyc & d_stb;

    // Read data is broadcast; only the ack carries the grant.
    assign i_dat_s = l2_dat_s;
    assign d_dat_s = l2_dat_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            state <= state_nxt;
            // Round-robin memory only moves when a grant is actually issued.
            if (state == IDLE && state_nxt == GNT_D) begin
                last_d <= 1'b1;
            end else if (state == IDLE && state_nxt == GNT_I) begin
                last_d <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        l2_cyc    = 1'b0;
        l2_stb    = 1'b0;
        l2_we     = 1'b0;
        l2_sel    = '0;
        l2_adr    = '0;
        l2_dat_m  = '0;
        i_ack     = 1'b0;
        d_ack     = 1'b0;

        case (state)
            IDLE: begin
                // An l2_ack seen here belongs to an abandoned transfer and is dropped.
                if (req_i && req_d) begin
                    state_nxt = last_d ? GNT_I : GNT_D;
                end else if (req_i) begin
                    state_nxt = GNT_I;
                end else if (req_d) begin
                    state_nxt = GNT_D;
                end
            end

            GNT_I: begin
                l2_cyc   = i_cyc;
                // stb is qualified by cyc so L2 never sees a strobe outside a cycle.
                l2_stb   = i_stb & i_cyc;
                l2_we    = i_we;
                l2_sel   = i_sel;
                l2_adr   = i_adr;
                l2_dat_m = i_dat_m;
                i_ack    = l2_ack;
                if (l2_ack || !i_cyc) begin
                    state_nxt = IDLE;
                end
            end

            GNT_D: begin
                l2_cyc   = d_cyc;
                l2_stb   = d_stb & d_cyc;
                l2_we    = d_we;
                l2_sel   = d_sel;
                l2_adr   = d_adr;
                l2_dat_m = d_dat_m;
                d_ack    = l2_ack;
                if (l2_ack || !d_cyc) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_cache_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wb_cache_arbiter
//
// Directed bench for wb_cache_arbiter. Inputs are driven 1 ns after the rising
// edge; outputs are sampled 1 ns later, well away from the next edge.
// ----------------------------------------------------------------------------
module tb_wb_cache_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 128;
    localparam int SEL_W  = 16;

    logic              clk;
    logic              rst_n;
    logic              i_cyc, i_stb, i_we;
    logic [SEL_W-1:0]  i_sel;
    logic [ADDR_W-1:0] i_adr;
    logic [DATA_W-1:0] i_dat_m, i_dat_s;
    logic              i_ack;
    logic              d_cyc, d_stb, d_we;
    logic [SEL_W-1:0]  d_sel;
    logic [ADDR_W-1:0] d_adr;
    logic [DATA_W-1:0] d_dat_m, d_dat_s;
    logic              d_ack;
    logic              l2_cyc, l2_stb, l2_we;
    logic [SEL_W-1:0]  l2_sel;
    logic [ADDR_W-1:0] l2_adr;
    logic [DATA_W-1:0] l2_dat_m, l2_dat_s;
    logic              l2_ack;

    int checks;
    int failures;
    logic [ADDR_W-1:0] exp_q[$];

    wb_cache_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cyc(i_cyc), .i_stb(i_stb), .i_we(i_we), .i_sel(i_sel),
        .i_adr(i_adr), .i_dat_m(i_dat_m), .i_dat_s(i_dat_s), .i_ack(i_ack),
        .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_sel(d_sel),
        .d_adr(d_adr), .d_dat_m(d_dat_m), .d_dat_s(d_dat_s), .d_ack(d_ack),
        .l2_cyc(l2_cyc), .l2_stb(l2_stb), .l2_we(l2_we), .l2_sel(l2_sel),
        .l2_adr(l2_adr), .l2_dat_m(l2_dat_m), .l2_dat_s(l2_dat_s), .l2_ack(l2_ack)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drive_i(input logic req, input logic we,
                           input logic [ADDR_W-1:0] adr);
        i_cyc = req; i_stb = req; i_we = we; i_adr = adr;
    endtask

    task automatic drive_d(input logic req, input logic we,
                           input logic [ADDR_W-1:0] adr);
        d_cyc = req; d_stb = req; d_we = we; d_adr = adr;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0;
        i_cyc = 0; i_stb = 0; i_we = 0; i_sel = '0; i_adr = '0; i_dat_m = '0;
        d_cyc = 0; d_stb = 0; d_we = 0; d_sel = '0; d_adr = '0; d_dat_m = '0;
        l2_dat_s = '0; l2_ack = 0;
        tick();
        settle();
        check("rst_l2_cyc", l2_cyc, 0);
        check("rst_l2_stb", l2_stb, 0);
        check("rst_acks", {i_ack, d_ack}, 0);
        rst_n = 1'b1;
        tick();

        // 1) icache read at 0x123
        drive_i(1, 0, 12'h123);
        i_sel = 16'hFFFF;
        i_dat_m = {4{32'hDEAD_BEEF}};
        settle();
        check("t1_no_passthru", l2_cyc, 0);
        tick();
        check("t1_l2_cyc", l2_cyc, 1);
        check("t1_l2_stb", l2_stb, 1);
        check("t1_l2_we", l2_we, 0);
        check("t1_l2_adr", l2_adr, 12'h123);
        check("t1_l2_sel", l2_sel, 16'hFFFF);
        l2_dat_s = {16{8'hA5}};
        l2_ack = 1;
        settle();
        check("t1_i_ack", i_ack, 1);
        check("t1_d_ack", d_ack, 0);
        check("t1_i_dat_s", i_dat_s, {16{8'hA5}});
        tick();
        drive_i(0, 0, 12'h000);
        l2_ack = 0;
        settle();
        check("t1_idle_cyc", l2_cyc, 0);
        check("t1_ack_once", i_ack, 0);

        // 2) dcache write at 0x0FF
        drive_d(1, 1, 12'h0FF);
        d_sel = 16'h00FF;
        d_dat_m = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        tick();
        check("t2_l2_we", l2_we, 1);
        check("t2_l2_adr", l2_adr, 12'h0FF);
        check("t2_l2_sel", l2_sel, 16'h00FF);
        check("t2_l2_dat_m", l2_dat_m, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677);
        check("t2_d_ack_wait", d_ack, 0);
        tick();
        check("t2_held", l2_cyc, 1);
        l2_ack = 1;
        settle();
        check("t2_d_ack", d_ack, 1);
        check("t2_i_ack", i_ack, 0);
        tick();
        drive_d(0, 0, 12'h000);
        l2_ack = 0;
        settle();
        check("t2_idle", l2_cyc, 0);

        // 3) tie right after reset
        do_reset();
        drive_i(1, 0, 12'h111);
        drive_d(1, 0, 12'h222);
        tick();
        check("t3_first_d", l2_adr, 12'h222);
        l2_ack = 1;
        settle();
        check("t3_d_ack", {i_ack, d_ack}, 2'b01);
        tick();
        drive_d(0, 0, 12'h222);
        l2_ack = 0;
        settle();
        check("t3_gap", l2_cyc, 0);
        check("t3_gap_acks", {i_ack, d_ack}, 2'b00);
        tick();
        check("t3_then_i", l2_adr, 12'h111);
        l2_ack = 1;
        settle();
        check("t3_i_ack", {i_ack, d_ack}, 2'b10);
        tick();
        l2_ack = 0;
        drive_d(1, 0, 12'h222);
        tick();
        check("t3_next_tie_d", l2_adr, 12'h222);
        l2_ack = 1;
        tick();
        l2_ack = 0;
        drive_i(0, 0, 12'h000);
        drive_d(0, 0, 12'h000);
        tick();

        // 4) icache aborts before ack
        drive_i(1, 0, 12'h333);
        tick();
        check("t4_granted", l2_cyc, 1);
        drive_i(0, 0, 12'h333);
        settle();
        check("t4_cyc_drop", l2_cyc, 0);
        tick();
        l2_ack = 1;
        settle();
        check("t4_late_ack", {i_ack, d_ack}, 2'b00);
        check("t4_idle", l2_cyc, 0);
        tick();
        l2_ack = 0;

        // 5) reset while GNT_D with ack pending (dcache is also last served)
        drive_d(1, 0, 12'h444);
        tick();
        l2_ack = 1;
        settle();
        check("t5_pre_d_ack", d_ack, 1);
        rst_n = 1'b0;
        settle();
        check("t5_async_cyc", l2_cyc, 0);
        check("t5_async_stb", l2_stb, 0);
        check("t5_async_d_ack", d_ack, 0);
        tick();
        l2_ack = 0;
        rst_n = 1'b1;
        drive_i(1, 0, 12'h555);
        tick();
        check("t5_tie_d", l2_adr, 12'h444);
        l2_ack = 1;
        tick();
        l2_ack = 0;
        drive_i(0, 0, 12'h000);
        drive_d(0, 0, 12'h000);
        tick();

        // 6) 20 back-to-back transfers, both masters always requesting
        do_reset();
        for (int n = 0; n < 20; n++) exp_q.push_back((n % 2 == 0) ? 12'hD0D : 12'h1C1);
        drive_i(1, 0, 12'h1C1);
        drive_d(1, 0, 12'hD0D);
        for (int n = 0; n < 20; n++) begin
            logic [ADDR_W-1:0] exp_adr;
            exp_adr = exp_q.pop_front();
            tick();
            check($sformatf("t6_grant%0d", n), l2_adr, exp_adr);
            l2_ack = 1;
            settle();
            check($sformatf("t6_acks%0d", n), {i_ack, d_ack},
                  (exp_adr == 12'hD0D) ? 2'b01 : 2'b10);
            tick();
            l2_ack = 0;
            settle();
            check($sformatf("t6_gap%0d", n), {l2_cyc, i_ack, d_ack}, 3'b000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
